registro_piso: RTL



---
 rtl/registro_piso.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/registro_piso.sv
// registro_piso: parallel-in, serial-out register with a valid/ready load
// handshake, clock-enable pacing and first/last-bit frame strobes.
// Serial outputs are registered from the next-state values, so the only
// combinational input-to-output path is load_ready through enable.
module registro_piso #(
  parameter int N         = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         enable,
  output logic         sout,
  output logic         notsout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [N-1:0]   sh_r;
  logic [N-1:0]   sh_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nx_s;
  logic           last_s;
  logic           accept_s;

  // Bit presented on the link for a given shift-register content.
  function automatic logic serial_bit(input logic [N-1:0] w);
    if (MSB_FIRST) begin
      return w[N-1];
    end else begin
      return w[0];
    end
  endfunction

  // Shift-register content after sending the current bit.
  function automatic logic [N-1:0] advance(input logic [N-1:0] w);
    if (MSB_FIRST) begin
      return w << 1;
    end else begin
      return w >> 1;
    end
  endfunction

  // Handshake: ready in IDLE, or on an enabled last bit for back-to-back words.
  always_comb begin
    last_s     = (state_r == SHIFT) && (cnt_r == CNT_LAST);
    load_ready = 1'b0;
    if (state_r == IDLE) begin
      load_ready = 1'b1;
    end else if (last_s && enable) begin
      load_ready = 1'b1;
    end else begin
      load_ready = 1'b0;
    end
    accept_s = load_valid && load_ready;
  end

  // Next-state logic: load, advance one bit, or finish the word.
  always_comb begin
    state_nx_s = state_r;
    sh_nx_s    = sh_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = SHIFT;
          sh_nx_s    = D;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (!enable) begin
          state_nx_s = SHIFT;
        end else if (!last_s) begin
          sh_nx_s  = advance(sh_r);
          cnt_nx_s = cnt_r + CNT_ONE;
        end else if (accept_s) begin
          sh_nx_s  = D;
          cnt_nx_s = CNT_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        sh_nx_s    = '0;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Core state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sh_r    <= '0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      sh_r    <= sh_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Registered serial outputs and frame strobes, aligned with the core state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sout        <= 1'b0;
      notsout     <= 1'b1;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sout        <= (state_nx_s == SHIFT) && serial_bit(sh_nx_s);
      notsout     <= !((state_nx_s == SHIFT) && serial_bit(sh_nx_s));
      sout_valid  <= (state_nx_s == SHIFT);
      frame_start <= (state_nx_s == SHIFT) && (cnt_nx_s == CNT_ZERO);
      frame_end   <= (state_nx_s == SHIFT) && (cnt_nx_s == CNT_LAST);
      busy        <= (state_nx_s == SHIFT);
    end
  end

endmodule
